fp_client_2x32: RTL and testbench
=================================

FP_CLIENT_2X32 -- requirements
Module: fp_client_2x32

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, and all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameters SHALL be:
- DEPTH, default 4: operand FIFO entries; power of two, at least 2.
- TIMEOUT, default 64: WAIT_Z cycles before the timeout flag sets.
REQ-003 Ports SHALL be:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- op_a  input  32  upstream operand A (IEEE-754 single).
- op_b  input  32  upstream operand B.
- op_valid  input  1  upstream operand pair valid.
- op_ready  output  1  FIFO can accept a pair.
- fp_a  output  32  operand A to the fp unit.
- fp_a_stb  output  1  fp_a valid.
- fp_a_ack  input  1  fp unit accepts A.
- fp_b  output  32  operand B to the fp unit.
- fp_b_stb  output  1  fp_b valid.
- fp_b_ack  input  1  fp unit accepts B.
- fp_z  input  32  result from the fp unit.
- fp_z_stb  input  1  fp_z valid.
- fp_z_ack  output  1  this block accepts fp_z.
- res_z  output  32  result to downstream.
- res_valid  output  1  res_z valid.
- res_ready  input  1  downstream accepts res_z.
- busy  output  1  state is not IDLE.
- timeout  output  1  sticky: a result was overdue.
- done_count  output  16  results received, wraps modulo 2^16.

Function
REQ-004 The block SHALL act as the initiator of the stb/ack protocol: a word transfers on a rising edge where that word's stb and ack are both high.
REQ-005 An upstream pair SHALL be pushed into the FIFO on an edge where op_valid and op_ready are both high; op_ready SHALL equal not-full.
REQ-006 FIFO pointers SHALL wrap modulo DEPTH, and a push and a pop on the same edge SHALL leave the count unchanged.
REQ-007 A push into an empty FIFO SHALL NOT be poppable until the following cycle.
REQ-008 The state machine SHALL have the states IDLE, SEND_A, SEND_B and WAIT_Z.
REQ-009 IDLE with the FIFO non-empty SHALL, on the next edge, pop the head into the fp_a/fp_b registers, set fp_a_stb and go to SEND_A.
REQ-010 SEND_A SHALL hold fp_a and fp_a_stb stable until an fp_a_stb&&fp_a_ack edge; that edge SHALL clear fp_a_stb, set fp_b_stb and go to SEND_B.
REQ-011 SEND_B SHALL behave the same way for B; its transfer edge SHALL clear fp_b_stb, clear the timeout counter and go to WAIT_Z.
REQ-012 In WAIT_Z, fp_z_ack SHALL be a registered output equal to 1 whenever res_valid is 0 on the next cycle, or res_valid is 1 and res_ready is 1.
REQ-013 An fp_z_stb&&fp_z_ack edge SHALL, at that edge:
- load res_z;
- set res_valid;
- clear fp_z_ack;
- increment done_count;
- return to IDLE.
REQ-014 res_valid SHALL clear on a res_valid&&res_ready edge unless a new result loads on that same edge, in which case it SHALL stay set.
REQ-015 A new operand pair SHALL be allowed to start while an earlier result is still held in res_z.
REQ-016 In WAIT_Z, the timeout counter SHALL increment on every cycle fp_z_stb is low and saturate at TIMEOUT.
REQ-017 When the counter reaches TIMEOUT, timeout SHALL set and stay set until rst; the block SHALL keep waiting and SHALL NOT abort.
REQ-018 fp_a_stb and fp_b_stb SHALL never be high in the same cycle.
REQ-019 Minimum latency SHALL be 1 cycle from FIFO non-empty to fp_a_stb high.

Reset
REQ-020 Asserting rst SHALL immediately clear:
- all stb/ack/valid outputs;
- busy, timeout and done_count;
- res_z, fp_a and fp_b (to 0);
- the FIFO (to empty).
The state SHALL return to IDLE.
REQ-021 A reset mid-transaction SHALL abandon the transaction; the fp unit SHALL be reset in the same cycle.

Structure
REQ-022 A shared package fp_hs_pkg SHALL hold the state encoding, FP_W=32, and the default DEPTH and TIMEOUT values.
REQ-023 The FIFO SHALL be a sub-module named fp_op_fifo (64-bit wide, DEPTH deep, with full and empty flags).

Verification
REQ-024 Basic add: push op_a=0x3F800000, op_b=0x40000000 to a responder model computing a+b; the bench SHALL see res_z=0x40400000, res_valid=1 and done_count=1.
REQ-025 FIFO full: push 5 pairs back-to-back with the responder stalled (acks low); op_ready SHALL drop after the 4th push and the 5th pair SHALL be held off.
REQ-026 Backpressure: hold res_ready=0 with one result pending; a second fp_z_stb SHALL see fp_z_ack=0 until res_ready=1 for one cycle, and both results SHALL arrive in order.
REQ-027 Timeout: with TIMEOUT=8 and a responder that never asserts fp_z_stb, timeout SHALL read 1 exactly 8 cycles after WAIT_Z entry and stay 1.
REQ-028 Reset in SEND_B: with fp_b_stb=1, pulse rst asynchronously; fp_b_stb, busy and op_ready SHALL go to 0, 0 and 1 immediately after rst deasserts, and done_count SHALL be 0.

Source files
------------

// File: rtl/fp_hs_pkg.sv
// Shared definitions for the fp operand client: data width, default sizing,
// handshake state encoding and the operand pair layout stored in the FIFO.
package fp_hs_pkg;

    localparam int FP_W        = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2,
        WAIT_Z = 2'd3
    } fp_state_e;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fp_pair_t;

    function automatic fp_pair_t make_pair(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
        fp_pair_t p;
        p.a = a;
        p.b = b;
        return p;
    endfunction

endpackage

// File: rtl/fp_op_fifo.sv
// Operand-pair FIFO: power-of-two depth, pointers wrap naturally, registered
// occupancy count so a fresh push is only visible as non-empty next cycle.
module fp_op_fifo
    import fp_hs_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 2 * FP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == {(AW+1){1'b0}});
    assign push_ok_s  = push_i && !full_o;
    assign pop_ok_s   = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fp_client_2x32.sv
// Initiator side of a two-operand stb/ack fp unit: buffers operand pairs,
// sends A then B, collects Z into a downstream valid/ready register.
module fp_client_2x32
    import fp_hs_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] op_a,
    input  logic [FP_W-1:0] op_b,
    input  logic            op_valid,
    output logic            op_ready,
    output logic [FP_W-1:0] fp_a,
    output logic            fp_a_stb,
    input  logic            fp_a_ack,
    output logic [FP_W-1:0] fp_b,
    output logic            fp_b_stb,
    input  logic            fp_b_ack,
    input  logic [FP_W-1:0] fp_z,
    input  logic            fp_z_stb,
    output logic            fp_z_ack,
    output logic [FP_W-1:0] res_z,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            busy,
    output logic            timeout,
    output logic [15:0]     done_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    fp_state_e       state_q, state_d;
    logic [FP_W-1:0] fp_a_q, fp_a_d;
    logic [FP_W-1:0] fp_b_q, fp_b_d;
    logic            fp_a_stb_q, fp_a_stb_d;
    logic            fp_b_stb_q, fp_b_stb_d;
    logic            fp_z_ack_q, fp_z_ack_d;
    logic [FP_W-1:0] res_z_q, res_z_d;
    logic            res_valid_q, res_valid_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [15:0]     done_count_q, done_count_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;

    logic            full_s;
    logic            empty_s;
    logic            pop_s;
    logic            load_s;
    fp_pair_t        push_pair_s;
    fp_pair_t        head_s;

    assign push_pair_s = make_pair(op_a, op_b);

    fp_op_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fp_pair_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (op_valid),
        .push_data_i (push_pair_s),
        .pop_i       (pop_s),
        .pop_data_o  (head_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

    assign op_ready   = !full_s;
    assign fp_a       = fp_a_q;
    assign fp_b       = fp_b_q;
    assign fp_a_stb   = fp_a_stb_q;
    assign fp_b_stb   = fp_b_stb_q;
    assign fp_z_ack   = fp_z_ack_q;
    assign res_z      = res_z_q;
    assign res_valid  = res_valid_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign done_count = done_count_q;

    // Handshake sequencer and result register next-state logic
    always_comb begin
        state_d      = state_q;
        fp_a_d       = fp_a_q;
        fp_b_d       = fp_b_q;
        fp_a_stb_d   = fp_a_stb_q;
        fp_b_stb_d   = fp_b_stb_q;
        res_z_d      = res_z_q;
        done_count_d = done_count_q;
        tcnt_d       = tcnt_q;
        pop_s        = 1'b0;
        load_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    fp_a_d     = head_s.a;
                    fp_b_d     = head_s.b;
                    fp_a_stb_d = 1'b1;
                    state_d    = SEND_A;
                end else begin
                    state_d    = IDLE;
                end
            end
            SEND_A: begin
                if (fp_a_stb_q && fp_a_ack) begin
                    fp_a_stb_d = 1'b0;
                    fp_b_stb_d = 1'b1;
                    state_d    = SEND_B;
                end else begin
                    state_d    = SEND_A;
                end
            end
            SEND_B: begin
                if (fp_b_stb_q && fp_b_ack) begin
                    fp_b_stb_d = 1'b0;
                    tcnt_d     = {TW{1'b0}};
                    state_d    = WAIT_Z;
                end else begin
                    state_d    = SEND_B;
                end
            end
            WAIT_Z: begin
                if (fp_z_stb && fp_z_ack_q) begin
                    load_s       = 1'b1;
                    res_z_d      = fp_z;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = IDLE;
                end else if (!fp_z_stb && (tcnt_q != TW'(TIMEOUT))) begin
                    tcnt_d       = tcnt_q + {{(TW-1){1'b0}}, 1'b1};
                end else begin
                    tcnt_d       = tcnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_s) begin
            res_valid_d = 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end

        // Ack Z only when the result register will be free to take it
        fp_z_ack_d = (state_d == WAIT_Z) && !res_valid_d;
        busy_d     = (state_d != IDLE);
        timeout_d  = timeout_q || (tcnt_d == TW'(TIMEOUT));
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fp_a_q       <= {FP_W{1'b0}};
            fp_b_q       <= {FP_W{1'b0}};
            fp_a_stb_q   <= 1'b0;
            fp_b_stb_q   <= 1'b0;
            fp_z_ack_q   <= 1'b0;
            res_z_q      <= {FP_W{1'b0}};
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            done_count_q <= 16'd0;
            tcnt_q       <= {TW{1'b0}};
        end else begin
            state_q      <= state_d;
            fp_a_q       <= fp_a_d;
            fp_b_q       <= fp_b_d;
            fp_a_stb_q   <= fp_a_stb_d;
            fp_b_stb_q   <= fp_b_stb_d;
            fp_z_ack_q   <= fp_z_ack_d;
            res_z_q      <= res_z_d;
            res_valid_q  <= res_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            done_count_q <= done_count_d;
            tcnt_q       <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_fp_client_2x32.sv
// Directed bench for fp_client_2x32: add, FIFO full, result backpressure,
// asynchronous reset in SEND_B and result timeout, with a table-driven fp unit.
module tb_fp_client_2x32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] fp_a;
    logic        fp_a_stb;
    logic        fp_a_ack = 1'b0;
    logic [31:0] fp_b;
    logic        fp_b_stb;
    logic        fp_b_ack = 1'b0;
    logic [31:0] fp_z = 32'd0;
    logic        fp_z_stb = 1'b0;
    logic        fp_z_ack;
    logic [31:0] res_z;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        timeout;
    logic [15:0] done_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_done = 0;
    logic [31:0] cap_a, cap_b;

    // Hand-computed single-precision sums: 1+2, 1+1, 2+2, .5+.5, 4+4, 1+.5
    logic [31:0] a_tab [6] = '{32'h3F800000, 32'h3F800000, 32'h40000000,
                               32'h3F000000, 32'h40800000, 32'h3F800000};
    logic [31:0] b_tab [6] = '{32'h40000000, 32'h3F800000, 32'h40000000,
                               32'h3F000000, 32'h40800000, 32'h3F000000};
    logic [31:0] z_tab [6] = '{32'h40400000, 32'h40000000, 32'h40800000,
                               32'h3F800000, 32'h41000000, 32'h3FC00000};

    fp_client_2x32 #(.DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .fp_a(fp_a), .fp_a_stb(fp_a_stb), .fp_a_ack(fp_a_ack),
        .fp_b(fp_b), .fp_b_stb(fp_b_stb), .fp_b_ack(fp_b_ack),
        .fp_z(fp_z), .fp_z_stb(fp_z_stb), .fp_z_ack(fp_z_ack),
        .res_z(res_z), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .timeout(timeout), .done_count(done_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // fp unit model: adds the operand pairs it knows about
    function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'hDEADBEEF;
        for (int i = 0; i < 6; i++) begin
            if (a == a_tab[i] && b == b_tab[i]) r = z_tab[i];
        end
        return r;
    endfunction

    task automatic push_pair(input int idx);
        op_a     = a_tab[idx];
        op_b     = b_tab[idx];
        op_valid = 1'b1;
        for (int i = 0; i < 100 && op_ready !== 1'b1; i++) @(negedge clk);
        check_val("push_ready", {31'd0, op_ready}, 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic send_ab(input int idx);
        for (int i = 0; i < 100 && fp_a_stb !== 1'b1; i++) @(negedge clk);
        check_val("a_stb", {31'd0, fp_a_stb}, 32'd1);
        check_val("ab_excl_a", {31'd0, fp_b_stb}, 32'd0);
        check_val("fp_a", fp_a, a_tab[idx]);
        cap_a    = fp_a;
        fp_a_ack = 1'b1;
        @(negedge clk);
        fp_a_ack = 1'b0;
        check_val("ab_excl_b", {31'd0, fp_a_stb}, 32'd0);
        check_val("b_stb", {31'd0, fp_b_stb}, 32'd1);
        check_val("fp_b", fp_b, b_tab[idx]);
        cap_b    = fp_b;
        fp_b_ack = 1'b1;
        @(negedge clk);
        fp_b_ack = 1'b0;
        check_val("b_stb_clr", {31'd0, fp_b_stb}, 32'd0);
        check_val("busy_wait", {31'd0, busy}, 32'd1);
    endtask

    task automatic return_z();
        fp_z     = fadd_model(cap_a, cap_b);
        fp_z_stb = 1'b1;
        for (int i = 0; i < 100 && fp_z_ack !== 1'b1; i++) @(negedge clk);
        check_val("z_ack", {31'd0, fp_z_ack}, 32'd1);
        @(negedge clk);
        fp_z_stb = 1'b0;
        exp_done++;
        check_val("z_ack_clr", {31'd0, fp_z_ack}, 32'd0);
        check_val("done_count", {16'd0, done_count}, exp_done);
    endtask

    task automatic drain(input int idx);
        check_val("res_valid", {31'd0, res_valid}, 32'd1);
        check_val("res_z", res_z, z_tab[idx]);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val("res_valid_clr", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check_val("rst_a_stb", {31'd0, fp_a_stb}, 32'd0);
        check_val("rst_b_stb", {31'd0, fp_b_stb}, 32'd0);
        check_val("rst_z_ack", {31'd0, fp_z_ack}, 32'd0);
        check_val("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check_val("rst_timeout", {31'd0, timeout}, 32'd0);
        check_val("rst_done", {16'd0, done_count}, 32'd0);
        check_val("rst_res_z", res_z, 32'd0);

        // Basic add 1.0 + 2.0, including one-cycle pop latency
        push_pair(0);
        check_val("lat_before", {31'd0, fp_a_stb}, 32'd0);
        @(negedge clk);
        check_val("lat_after", {31'd0, fp_a_stb}, 32'd1);
        send_ab(0);
        return_z();
        check_val("add_res", res_z, 32'h40400000);
        check_val("add_done", {16'd0, done_count}, 32'd1);
        drain(0);

        // FIFO full: pair 0 stalls in SEND_A, then five back-to-back pushes
        push_pair(0);
        @(negedge clk);
        check_val("stall_a_stb", {31'd0, fp_a_stb}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            op_a = a_tab[k];
            op_b = b_tab[k];
            op_valid = 1'b1;
            check_val($sformatf("fill_ready_%0d", k), {31'd0, op_ready}, 32'd1);
            @(negedge clk);
        end
        op_a = a_tab[5];
        op_b = b_tab[5];
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("full_hold_%0d", k), {31'd0, op_ready}, 32'd0);
            @(negedge clk);
        end
        op_valid = 1'b0;
        send_ab(0);
        return_z();
        drain(0);
        push_pair(5);
        for (int k = 1; k <= 5; k++) begin
            send_ab(k);
            return_z();
            drain(k);
        end
        repeat (3) @(negedge clk);
        check_val("fifo_drained_busy", {31'd0, busy}, 32'd0);
        check_val("fifo_drained_stb", {31'd0, fp_a_stb}, 32'd0);

        // Backpressure: first result held, second Z must wait for res_ready
        push_pair(2);
        push_pair(3);
        send_ab(2);
        return_z();
        send_ab(3);
        fp_z     = fadd_model(cap_a, cap_b);
        fp_z_stb = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("bp_ack_low_%0d", k), {31'd0, fp_z_ack}, 32'd0);
            @(negedge clk);
        end
        check_val("bp_hold_res", res_z, z_tab[2]);
        check_val("bp_hold_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val("bp_res_clr", {31'd0, res_valid}, 32'd0);
        check_val("bp_ack_high", {31'd0, fp_z_ack}, 32'd1);
        return_z();
        drain(3);
        check_val("no_timeout_yet", {31'd0, timeout}, 32'd0);

        // Asynchronous reset while B is presented and the FIFO is full
        push_pair(4);
        for (int k = 0; k < 4; k++) push_pair(k);
        check_val("pre_rst_full", {31'd0, op_ready}, 32'd0);
        for (int i = 0; i < 100 && fp_a_stb !== 1'b1; i++) @(negedge clk);
        fp_a_ack = 1'b1;
        @(negedge clk);
        fp_a_ack = 1'b0;
        check_val("pre_rst_b_stb", {31'd0, fp_b_stb}, 32'd1);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        exp_done = 0;
        check_val("arst_b_stb", {31'd0, fp_b_stb}, 32'd0);
        check_val("arst_busy", {31'd0, busy}, 32'd0);
        check_val("arst_op_ready", {31'd0, op_ready}, 32'd1);
        check_val("arst_done", {16'd0, done_count}, 32'd0);
        check_val("arst_fp_a", fp_a, 32'd0);
        check_val("arst_res_z", res_z, 32'd0);
        repeat (3) @(negedge clk);
        check_val("arst_fifo_empty", {31'd0, fp_a_stb}, 32'd0);

        // Timeout: Z never strobed, flag sets eight cycles after WAIT_Z entry
        push_pair(0);
        send_ab(0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check_val($sformatf("tmo_c%0d", k), {31'd0, timeout}, (k == 8) ? 32'd1 : 32'd0);
        end
        repeat (4) @(negedge clk);
        check_val("tmo_sticky", {31'd0, timeout}, 32'd1);
        check_val("tmo_still_busy", {31'd0, busy}, 32'd1);
        return_z();
        drain(0);
        check_val("tmo_after_done", {31'd0, timeout}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
